// File: rtl/mem_access_unit.sv
// Load/store front end to a word-wide memory: byte/half/word accesses, sub-word stores by read-modify-write.
// Optional macro MEM_MISALIGN_TRAP_EN: misaligned half/word accesses skip memory and complete at once with misalign=1.
module mem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              signExt,
  input  logic [ADDR_W-1:0] cpuAddr,
  input  logic [31:0]       cpuWData,
  output logic              ready,
  output logic              done,
  output logic [31:0]       rData,
  output logic              misalign,
  output logic [31:0]       memAddress,
  output logic [31:0]       memWriteData,
  output logic              memWriteEnable,
  input  logic [31:0]       memData
);

  // state   | meaning
  // S_IDLE  | waiting for req, ready=1
  // S_READ  | memData sampled: load extract or store merge
  // S_WRITE | memWriteEnable=1 for one cycle
  // S_DONE  | done pulse, back to idle
  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sext_q, sext_d;
  logic [1:0]  lo_q, lo_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] maddr_q, maddr_d;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        mis_q, mis_d;
`endif

  logic        req_mis;
  logic [1:0]  req_lo;
  logic [4:0]  sh_amt;
  logic [31:0] rd_shift, lane_mask, load_val, merged;

  assign req_mis = (size == 2'b01 && cpuAddr[0]) || (size[1] && cpuAddr[1:0] != 2'b00);
  // Low bits are forced aligned per access size; with the trap enabled misaligned requests never use them.
  assign req_lo  = (size == 2'b00) ? cpuAddr[1:0] :
                   (size == 2'b01) ? {cpuAddr[1], 1'b0} : 2'b00;

  assign sh_amt    = {lo_q, 3'b000};
  assign rd_shift  = memData >> sh_amt;
  assign lane_mask = ((size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << sh_amt;
  assign merged    = (memData & ~lane_mask) | ((wdata_q << sh_amt) & lane_mask);

  always_comb begin
    case (size_q)
      2'b00:   load_val = {{24{sext_q & rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   load_val = {{16{sext_q & rd_shift[15]}}, rd_shift[15:0]};
      default: load_val = memData;
    endcase
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    sext_d  = sext_q;
    lo_d    = lo_q;
    wdata_d = wdata_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    maddr_d = maddr_q;
`ifdef MEM_MISALIGN_TRAP_EN
    mis_d   = mis_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          size_d  = size;
          sext_d  = signExt;
          lo_d    = req_lo;
          wdata_d = cpuWData;
          maddr_d = 32'(cpuAddr >> 2);
          if (!we)          state_d = S_READ;
          else if (size[1]) state_d = S_WRITE;
          else              state_d = S_READ;
`ifdef MEM_MISALIGN_TRAP_EN
          mis_d = req_mis;
          if (req_mis) state_d = S_DONE;
`endif
        end
      end
      S_READ: begin
        if (we_q) begin
          merge_d = merged;
          state_d = S_WRITE;
        end else begin
          rdata_d = load_val;
          state_d = S_DONE;
        end
      end
      S_WRITE: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sext_q  <= 1'b0;
      lo_q    <= 2'b00;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      maddr_q <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      lo_q    <= lo_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      maddr_q <= maddr_d;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q   <= mis_d;
`endif
    end
  end

  assign ready          = (state_q == S_IDLE);
  assign done           = (state_q == S_DONE);
  assign rData          = rdata_q;
  assign memAddress     = maddr_q;
  assign memWriteEnable = (state_q == S_WRITE);
  assign memWriteData   = (state_q != S_WRITE) ? 32'h0 : (size_q[1] ? wdata_q : merge_q);
`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = (state_q == S_DONE) && mis_q;
`else
  assign misalign = 1'b0;
  logic unused_ok;
  assign unused_ok = req_mis;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 64-word behavioural memory.
module tb_mem_access_unit;
  logic        Clk = 1'b0, Rst_n = 1'b0, req = 1'b0, we = 1'b0, signExt = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] cpuAddr = '0, cpuWData = '0;
  logic        ready, done, misalign, memWriteEnable;
  logic [31:0] rData, memAddress, memWriteData, memData;
  logic [31:0] mem [0:63];
  int tests = 0, fails = 0;

  mem_access_unit #(.ADDR_W(32)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .req(req), .we(we), .size(size), .signExt(signExt),
    .cpuAddr(cpuAddr), .cpuWData(cpuWData), .ready(ready), .done(done), .rData(rData),
    .misalign(misalign), .memAddress(memAddress), .memWriteData(memWriteData),
    .memWriteEnable(memWriteEnable), .memData(memData)
  );

  always #5 Clk = ~Clk;
  assign memData = mem[memAddress[5:0]];
  always @(posedge Clk) if (memWriteEnable) mem[memAddress[5:0]] <= memWriteData;

  // One access; lat counts cycles from the accept edge to the done cycle (12 = timed out).
  task automatic do_acc(input logic w, input logic [1:0] sz, input logic sx, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output int wen_n, output logic mis,
                        output logic [31:0] waddr, output logic [31:0] wdat);
    int guard;
    lat = 0; wen_n = 0; mis = 1'b0; waddr = '0; wdat = '0; guard = 0;
    @(negedge Clk);
    while (!ready && guard < 20) begin @(negedge Clk); guard++; end
    we = w; size = sz; signExt = sx; cpuAddr = a; cpuWData = d; req = 1'b1;
    @(posedge Clk); #1 req = 1'b0;
    do begin
      @(negedge Clk); lat++;
      if (memWriteEnable) begin wen_n++; waddr = memAddress; wdat = memWriteData; end
    end while (!done && lat < 12);
    mis = misalign;
  endtask

  task automatic test_reset();
    #2;
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", ready); end
    tests++; if ({done, misalign, memWriteEnable} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b exp 000", {done, misalign, memWriteEnable}); end
    tests++; if ({rData, memAddress, memWriteData} !== 96'h0) begin fails++; $display("FAIL reset_data got %h exp 0", {rData, memAddress, memWriteData}); end
    @(negedge Clk); Rst_n = 1'b1;
  endtask

  task automatic test_word_store();
    int lat, wn; logic mis; logic [31:0] wa, wd;
    do_acc(1'b1, 2'b10, 1'b0, 32'h3C, 32'hFFFF_FFFF, lat, wn, mis, wa, wd);
    tests++; if (lat !== 2) begin fails++; $display("FAIL sw_latency got %0d exp 2", lat); end
    tests++; if (wn !== 1) begin fails++; $display("FAIL sw_wen_cycles got %0d exp 1", wn); end
    tests++; if (wa !== 32'h0F) begin fails++; $display("FAIL sw_addr got %h exp 0000000f", wa); end
    tests++; if (wd !== 32'hFFFF_FFFF) begin fails++; $display("FAIL sw_wdata got %h exp ffffffff", wd); end
    do_acc(1'b0, 2'b10, 1'b0, 32'h3C, 32'h0, lat, wn, mis, wa, wd);
    tests++; if (lat !== 2) begin fails++; $display("FAIL lw_latency got %0d exp 2", lat); end
    tests++; if (rData !== 32'hFFFF_FFFF) begin fails++; $display("FAIL lw_data got %h exp ffffffff", rData); end
    tests++; if (wn !== 0 || mis !== 1'b0) begin fails++; $display("FAIL lw_side got wen=%0d mis=%b exp 0 0", wn, mis); end
  endtask

  task automatic test_subword_store();
    int lat, wn; logic mis; logic [31:0] wa, wd;
    do_acc(1'b1, 2'b10, 1'b0, 32'h3C, 32'h1122_3344, lat, wn, mis, wa, wd);
    do_acc(1'b1, 2'b00, 1'b0, 32'h3D, 32'h0000_005A, lat, wn, mis, wa, wd);
    tests++; if (lat !== 3) begin fails++; $display("FAIL sb_latency got %0d exp 3", lat); end
    tests++; if (wn !== 1) begin fails++; $display("FAIL sb_wen_cycles got %0d exp 1", wn); end
    tests++; if (wd !== 32'h1122_5A44) begin fails++; $display("FAIL sb_merge got %h exp 11225a44", wd); end
    do_acc(1'b1, 2'b01, 1'b0, 32'h3E, 32'h0000_BEEF, lat, wn, mis, wa, wd);
    tests++; if (lat !== 3 || wd !== 32'hBEEF_5A44) begin fails++; $display("FAIL sh_merge got lat=%0d data=%h exp 3 beef5a44", lat, wd); end
    do_acc(1'b0, 2'b10, 1'b0, 32'h3C, 32'h0, lat, wn, mis, wa, wd);
    tests++; if (rData !== 32'hBEEF_5A44) begin fails++; $display("FAIL sub_readback got %h exp beef5a44", rData); end
  endtask

  task automatic test_subword_load();
    int lat, wn; logic mis; logic [31:0] wa, wd;
    do_acc(1'b0, 2'b00, 1'b1, 32'h3E, 32'h0, lat, wn, mis, wa, wd);
    tests++; if (rData !== 32'hFFFF_FFEF) begin fails++; $display("FAIL lb_sext got %h exp ffffffef", rData); end
    do_acc(1'b0, 2'b00, 1'b0, 32'h3E, 32'h0, lat, wn, mis, wa, wd);
    tests++; if (rData !== 32'h0000_00EF) begin fails++; $display("FAIL lb_zext got %h exp 000000ef", rData); end
    do_acc(1'b0, 2'b00, 1'b0, 32'h3F, 32'h0, lat, wn, mis, wa, wd);
    tests++; if (rData !== 32'h0000_00BE) begin fails++; $display("FAIL lb_lane3 got %h exp 000000be", rData); end
    do_acc(1'b0, 2'b01, 1'b1, 32'h3E, 32'h0, lat, wn, mis, wa, wd);
    tests++; if (rData !== 32'hFFFF_BEEF) begin fails++; $display("FAIL lh_hi_sext got %h exp ffffbeef", rData); end
    do_acc(1'b0, 2'b01, 1'b1, 32'h3C, 32'h0, lat, wn, mis, wa, wd);
    tests++; if (rData !== 32'h0000_5A44 || lat !== 2) begin fails++; $display("FAIL lh_lo got %h lat=%0d exp 00005a44 2", rData, lat); end
  endtask

  task automatic test_misaligned();
    int lat, wn; logic mis; logic [31:0] wa, wd;
    do_acc(1'b0, 2'b10, 1'b0, 32'h3D, 32'h0, lat, wn, mis, wa, wd);
`ifdef MEM_MISALIGN_TRAP_EN
    tests++; if (lat !== 1 || mis !== 1'b1) begin fails++; $display("FAIL mis_trap got lat=%0d mis=%b exp 1 1", lat, mis); end
    tests++; if (rData !== 32'h0000_5A44 || wn !== 0) begin fails++; $display("FAIL mis_hold got %h wen=%0d exp 00005a44 0", rData, wn); end
`else
    tests++; if (lat !== 2 || mis !== 1'b0) begin fails++; $display("FAIL mis_align got lat=%0d mis=%b exp 2 0", lat, mis); end
    tests++; if (rData !== 32'hBEEF_5A44) begin fails++; $display("FAIL mis_data got %h exp beef5a44", rData); end
`endif
  endtask

  task automatic test_busy_req();
    int lat, wn, guard; logic mis; logic [31:0] wa, wd;
    guard = 0;
    @(negedge Clk);
    while (!ready && guard < 20) begin @(negedge Clk); guard++; end
    we = 1'b1; size = 2'b00; signExt = 1'b0; cpuAddr = 32'h3C; cpuWData = 32'h77; req = 1'b1;
    @(posedge Clk); #1 cpuAddr = 32'h0; cpuWData = 32'hDEAD_0000; size = 2'b10;
    for (int c = 1; c <= 3; c++) begin
      @(negedge Clk);
      tests++; if (ready !== 1'b0 || memAddress !== 32'h0F) begin fails++; $display("FAIL busy_c%0d got ready=%b addr=%h exp 0 0000000f", c, ready, memAddress); end
      if (c == 2) begin
        tests++; if (memWriteEnable !== 1'b1 || memWriteData !== 32'hBEEF_5A77) begin fails++; $display("FAIL busy_write got wen=%b data=%h exp 1 beef5a77", memWriteEnable, memWriteData); end
      end
      if (c == 3) begin
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL busy_done got %b exp 1", done); end
      end
    end
    req = 1'b0;
    @(negedge Clk);
    tests++; if (ready !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL busy_ready got ready=%b done=%b exp 1 0", ready, done); end
    do_acc(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, lat, wn, mis, wa, wd);
    tests++; if (rData !== 32'h0) begin fails++; $display("FAIL busy_noqueue got %h exp 00000000", rData); end
    do_acc(1'b0, 2'b10, 1'b0, 32'h3C, 32'h0, lat, wn, mis, wa, wd);
    tests++; if (rData !== 32'hBEEF_5A77) begin fails++; $display("FAIL busy_store got %h exp beef5a77", rData); end
  endtask

  task automatic test_reset_in_write();
    int lat, wn; logic mis; logic [31:0] wa, wd;
    @(negedge Clk);
    we = 1'b1; size = 2'b10; cpuAddr = 32'h3C; cpuWData = 32'hCAFE_F00D; req = 1'b1;
    @(posedge Clk); #1 req = 1'b0;
    @(negedge Clk);
    tests++; if (memWriteEnable !== 1'b1) begin fails++; $display("FAIL rst_pre_wen got %b exp 1", memWriteEnable); end
    Rst_n = 1'b0; #1;
    tests++; if ({ready, done, misalign, memWriteEnable} !== 4'b1000) begin fails++; $display("FAIL rst_async_flags got %b exp 1000", {ready, done, misalign, memWriteEnable}); end
    tests++; if ({rData, memAddress, memWriteData} !== 96'h0) begin fails++; $display("FAIL rst_async_data got %h exp 0", {rData, memAddress, memWriteData}); end
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL rst_no_done got %b exp 0", done); end
    end
    do_acc(1'b0, 2'b10, 1'b0, 32'h3C, 32'h0, lat, wn, mis, wa, wd);
    tests++; if (rData !== 32'hBEEF_5A77) begin fails++; $display("FAIL rst_mem_kept got %h exp beef5a77", rData); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    test_reset();
    test_word_store();
    test_subword_store();
    test_subword_load();
    test_misaligned();
    test_busy_req();
    test_reset_in_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store front end between the datapath and the word-wide `Memory` block. Accepts byte/halfword/word loads and stores at byte addresses, drives `Memory`'s `Address`/`writeData`/`writeEnable`, and consumes `MemData`. Sub-word stores use a read-modify-write sequence. Load results are returned aligned and zero- or sign-extended.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width (data path fixed at 32 bits)

Ports:
- `Clk`  in  1  single clock, rising edge
- `Rst_n`  in  1  reset, asynchronous, active-low
- `req`  in  1  access request, accepted only when `ready`=1
- `we`  in  1  1 = store, 0 = load
- `size`  in  2  00 byte, 01 half, 10 word, 11 treated as word
- `signExt`  in  1  loads: 1 sign-extend, 0 zero-extend
- `cpuAddr`  in  ADDR_W  byte address
- `cpuWData`  in  32  store data, right-justified
- `ready`  out  1  unit idle, can accept `req`
- `done`  out  1  one-cycle completion pulse
- `rData`  out  32  load result, held until the next load completes
- `misalign`  out  1  misaligned-access flag, coincident with `done`
- `memAddress`  out  32  to `Memory.Address`, word index
- `memWriteData`  out  32  to `Memory.writeData`
- `memWriteEnable`  out  1  to `Memory.writeEnable`
- `memData`  in  32  from `Memory.MemData`, combinational read of `memAddress`

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
  - `ready`=1 only in IDLE.
  - `done`=1 only in DONE; DONE always returns to IDLE.
- Accept: in IDLE with `req`=1, register `we`, `size`, `signExt`, `cpuAddr`, and `cpuWData`, then choose the next state:
  - Load: READ.
  - Word store: WRITE.
  - Byte or half store: READ.
  - Misaligned access (macro on): DONE.
- `memAddress` = `{2'b00, addr[31:2]}` of the captured address. It is loaded at accept and held while IDLE.
- Lane mapping is little-endian: byte k = bits [8k+7:8k]; half at `addr[1]` = bits [16·addr[1]+15 : 16·addr[1]].
- READ:
  - Load: extract the byte or half from `memData`, extend it, and register the result into `rData` at the edge leaving READ. Next state DONE.
  - Sub-word store: register `memData` into the merge register, replace the addressed lane(s) with `cpuWData` low bits. Next state WRITE.
- WRITE:
  - `memWriteEnable`=1 and `memWriteData` = merged word, or `cpuWData` for a word store.
  - The write commits at the edge leaving WRITE. Next state DONE.
- `memWriteEnable` is 1 only in WRITE, for exactly one cycle per store.
- `req` while not in IDLE is ignored, not queued.
- Reset values:
  - state IDLE, `ready`=1
  - `done`=0, `misalign`=0, `memWriteEnable`=0
  - `rData`=0, `memAddress`=0, `memWriteData`=0, merge register 0

## Timing
- Cycle 0 ends at the accept edge. Latency to the `done` cycle:
  - Load: READ in cycle 1, `done` in cycle 2.
  - Word store: WRITE in cycle 1, `done` in cycle 2.
  - Sub-word store: READ, WRITE, then `done` in cycle 3.
  - Misaligned (macro on): `done` in cycle 1.
- `ready` returns the cycle after `done`. Back-to-back throughput is 1 access per 3 cycles for loads and word stores, and 1 per 4 cycles for sub-word stores.
- `rData` is valid when `done`=1. `rData` is unchanged by stores and by misaligned loads.
- `Rst_n` low at any point:
  - All outputs clear immediately.
  - Asserted during WRITE: `memWriteEnable` drops before the edge, so no write occurs.
  - An in-flight access is abandoned with no `done`.

## Configuration
- Macro `MEM_MISALIGN_TRAP_EN`.
- Defined:
  - A half access with `addr[0]`=1, or a word access with `addr[1:0]`≠0, performs no memory read or write.
  - FSM goes straight to DONE with `misalign`=1 for that cycle.
- Undefined:
  - Low address bits are forced aligned: half ignores `addr[0]`, word ignores `addr[1:0]`.
  - `misalign` is tied to 0.

## Test plan
- Reset: pulse `Rst_n` low mid-cycle -> all outputs at reset values asynchronously, `ready`=1.
- Word store then load: sw `0xFFFFFFFF` @ `0x3C` -> `memAddress`=`0x0F`, `memWriteEnable` high exactly 1 cycle, `done` in cycle 2. Then lw `0x3C` -> `rData`=`0xFFFFFFFF` in cycle 2.
- Sub-word store: word `0x11223344` @ `0x3C`, then sb `0x5A` @ `0x3D` -> memory `0x11225A44`, `done` in cycle 3. Then sh `0xBEEF` @ `0x3E` -> `0xBEEF5A44`.
- Sub-word loads on `0xBEEF5A44`:
  - lb `0x3E`, signExt=1 -> `0xFFFFFFEF`; signExt=0 -> `0x000000EF`.
  - lh `0x3C`, signExt=1 -> `0x00005A44`.
- Misaligned lw @ `0x3D`:
  - Macro on: `done`+`misalign` in cycle 1, no `memWriteEnable`, `rData` unchanged.
  - Macro off: returns word @ `0x3C`.
- Robustness:
  - `req` held during a busy sub-word store -> ignored until `ready`.
  - `Rst_n` asserted in WRITE -> memory word unchanged on readback.
